// File: rtl/alu_operand_stage_pkg.sv
// ---------------------------------------------------------------------------
// alu_operand_stage_pkg
// Purpose : Shared widths, ALU function codes and flag bit positions for the
//           operand/issue stage and the 8-bit ALU it feeds.
// Contents: DATA_W / REG_ADDR_W / FUNC_W widths, alu_func_e codes,
//           FLAG_Z/S/V indices into the 3-bit flag word, and func_writes(),
//           which tells whether a function code produces a register write.
// ---------------------------------------------------------------------------
package alu_operand_stage_pkg;

    localparam int DATA_W     = 8;
    localparam int REG_ADDR_W = 3;
    localparam int FUNC_W     = 3;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;
    localparam int FLAG_W     = 3;

    // Flag word layout: {ovf, sign, zero}
    localparam int FLAG_Z = 0;
    localparam int FLAG_S = 1;
    localparam int FLAG_V = 2;

    typedef enum logic [FUNC_W-1:0] {
        ALU_NOP = 3'd0,
        ALU_ADD = 3'd1,
        ALU_SUB = 3'd2,
        ALU_AND = 3'd3,
        ALU_OR  = 3'd4,
        ALU_XOR = 3'd5
    } alu_func_e;

    // Codes 0, 6 and 7 are treated as no-ops: no writeback, no flag update.
    function automatic logic func_writes(input logic [FUNC_W-1:0] f);
        logic w;
        case (f)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR: w = 1'b1;
            default:                                    w = 1'b0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/alu_operand_stage_if.sv
// ---------------------------------------------------------------------------
// alu_operand_stage_if
// Purpose : Instruction issue channel into the operand stage.
// Signals : in_valid/in_ready handshake (transfer when both high),
//           in_func, in_rd, in_rs, in_rt, in_imm_en, in_imm.
// Modports: master = instruction source, slave = operand stage.
// ---------------------------------------------------------------------------
interface alu_operand_stage_if;
    import alu_operand_stage_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [FUNC_W-1:0]     in_func;
    logic [REG_ADDR_W-1:0] in_rd;
    logic [REG_ADDR_W-1:0] in_rs;
    logic [REG_ADDR_W-1:0] in_rt;
    logic                  in_imm_en;
    logic [DATA_W-1:0]     in_imm;

    modport master (
        output in_valid, in_func, in_rd, in_rs, in_rt, in_imm_en, in_imm,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_func, in_rd, in_rs, in_rt, in_imm_en, in_imm,
        output in_ready
    );

endinterface

// File: rtl/alu_operand_stage_regfile.sv
// ---------------------------------------------------------------------------
// alu_operand_stage_regfile
// Purpose : 8x8 register file, R0 hardwired to zero.
// Ports   : i_clk, i_rst (sync, active high, clears all registers)
//           i_we/i_waddr/i_wdata  synchronous write port (writes to R0 dropped)
//           i_raddr_a/o_rdata_a   async read port (operand A)
//           i_raddr_b/o_rdata_b   async read port (operand B)
//           i_raddr_d/o_rdata_d   async read port (debug)
// ---------------------------------------------------------------------------
module alu_operand_stage_regfile
    import alu_operand_stage_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_we,
    input  logic [REG_ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic [REG_ADDR_W-1:0] i_raddr_a,
    input  logic [REG_ADDR_W-1:0] i_raddr_b,
    input  logic [REG_ADDR_W-1:0] i_raddr_d,
    output logic [DATA_W-1:0]     o_rdata_a,
    output logic [DATA_W-1:0]     o_rdata_b,
    output logic [DATA_W-1:0]     o_rdata_d
);

    logic [DATA_W-1:0] r_mem [0:NUM_REGS-1];

    // Register storage: synchronous clear and write; R0 is never written.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= {DATA_W{1'b0}};
            end
        end else if (i_we && (i_waddr != {REG_ADDR_W{1'b0}})) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Async reads; R0 forced to zero independently of storage.
    always_comb begin
        o_rdata_a = {DATA_W{1'b0}};
        o_rdata_b = {DATA_W{1'b0}};
        o_rdata_d = {DATA_W{1'b0}};
        if (i_raddr_a != {REG_ADDR_W{1'b0}}) o_rdata_a = r_mem[i_raddr_a];
        else                                 o_rdata_a = {DATA_W{1'b0}};
        if (i_raddr_b != {REG_ADDR_W{1'b0}}) o_rdata_b = r_mem[i_raddr_b];
        else                                 o_rdata_b = {DATA_W{1'b0}};
        if (i_raddr_d != {REG_ADDR_W{1'b0}}) o_rdata_d = r_mem[i_raddr_d];
        else                                 o_rdata_d = {DATA_W{1'b0}};
    end

endmodule

// File: rtl/alu_operand_stage.sv
// ---------------------------------------------------------------------------
// alu_operand_stage
// Purpose : Two-stage (ISSUE, EXEC/WB) operand stage in front of the 8-bit
//           ALU. Reads operands (with bypass from the op currently in EXEC),
//           registers op1/op2/func into the ALU, writes the ALU result back
//           and latches {ovf,sign,zero}.
// Ports   : i_clk, i_rst          clock, synchronous active-high reset
//           bus (slave)           instruction issue handshake + fields
//           i_stall               downstream hold; freezes the EXEC stage
//           o_alu_op1/op2/func    registered ALU inputs
//           i_alu_result/zero/sign/ovf  ALU combinational outputs
//           o_flags               {ovf,sign,zero} of last committed op
//           o_wb_valid            one-cycle pulse after a writeback commits
//           i_dbg_addr/o_dbg_data combinational debug register read
// ---------------------------------------------------------------------------
module alu_operand_stage
    import alu_operand_stage_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_rst,
    alu_operand_stage_if.slave     bus,
    input  logic                   i_stall,
    output logic [DATA_W-1:0]      o_alu_op1,
    output logic [DATA_W-1:0]      o_alu_op2,
    output logic [FUNC_W-1:0]      o_alu_func,
    input  logic [DATA_W-1:0]      i_alu_result,
    input  logic                   i_alu_zero,
    input  logic                   i_alu_sign,
    input  logic                   i_alu_ovf,
    output logic [FLAG_W-1:0]      o_flags,
    output logic                   o_wb_valid,
    input  logic [REG_ADDR_W-1:0]  i_dbg_addr,
    output logic [DATA_W-1:0]      o_dbg_data
);

    logic                  r_ex_valid;
    logic [REG_ADDR_W-1:0] r_ex_rd;
    logic [DATA_W-1:0]     r_op1;
    logic [DATA_W-1:0]     r_op2;
    logic [FUNC_W-1:0]     r_func;
    logic [FLAG_W-1:0]     r_flags;
    logic                  r_wb_valid;

    logic                  w_hold;
    logic                  w_commit;
    logic                  w_accept;
    logic                  w_bypass;
    logic [DATA_W-1:0]     w_rf_rs;
    logic [DATA_W-1:0]     w_rf_rt;
    logic [DATA_W-1:0]     w_op1;
    logic [DATA_W-1:0]     w_op2;
    logic [FLAG_W-1:0]     w_alu_flags;

    // EXEC is frozen only when it actually holds an op.
    assign w_hold   = r_ex_valid & i_stall;
    // Reset wins over a commit so an in-flight op is dropped cleanly.
    assign w_commit = r_ex_valid & ~i_stall & func_writes(r_func) & ~i_rst;
    assign bus.in_ready = ~i_rst & ~w_hold;
    assign w_accept = bus.in_valid & bus.in_ready;

    // The result being committed this cycle is forwarded so a dependent op
    // issued right behind it needs no bubble. R0 is never forwarded.
    assign w_bypass = r_ex_valid & ~i_stall & func_writes(r_func)
                    & (r_ex_rd != {REG_ADDR_W{1'b0}});

    always_comb begin
        w_alu_flags         = {FLAG_W{1'b0}};
        w_alu_flags[FLAG_V] = i_alu_ovf;
        w_alu_flags[FLAG_S] = i_alu_sign;
        w_alu_flags[FLAG_Z] = i_alu_zero;
    end

    alu_operand_stage_regfile u_regfile (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_we      (w_commit),
        .i_waddr   (r_ex_rd),
        .i_wdata   (i_alu_result),
        .i_raddr_a (bus.in_rs),
        .i_raddr_b (bus.in_rt),
        .i_raddr_d (i_dbg_addr),
        .o_rdata_a (w_rf_rs),
        .o_rdata_b (w_rf_rt),
        .o_rdata_d (o_dbg_data)
    );

    // Operand selection: bypass over register file, immediate over rt.
    always_comb begin
        w_op1 = w_rf_rs;
        w_op2 = w_rf_rt;
        if (w_bypass && (r_ex_rd == bus.in_rs)) w_op1 = i_alu_result;
        else                                    w_op1 = w_rf_rs;
        if (bus.in_imm_en)                           w_op2 = bus.in_imm;
        else if (w_bypass && (r_ex_rd == bus.in_rt)) w_op2 = i_alu_result;
        else                                         w_op2 = w_rf_rt;
    end

    // EX pipeline registers: hold on stall, load on accept, else idle the ALU.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ex_valid <= 1'b0;
            r_ex_rd    <= {REG_ADDR_W{1'b0}};
            r_op1      <= {DATA_W{1'b0}};
            r_op2      <= {DATA_W{1'b0}};
            r_func     <= ALU_NOP;
        end else if (w_hold) begin
            r_ex_valid <= r_ex_valid;
        end else if (w_accept) begin
            r_ex_valid <= 1'b1;
            r_ex_rd    <= bus.in_rd;
            r_op1      <= w_op1;
            r_op2      <= w_op2;
            r_func     <= bus.in_func;
        end else begin
            r_ex_valid <= 1'b0;
            r_func     <= ALU_NOP;
        end
    end

    // Flag register and writeback pulse, updated only by committing ops.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_flags    <= {FLAG_W{1'b0}};
            r_wb_valid <= 1'b0;
        end else begin
            r_wb_valid <= w_commit;
            if (w_commit) r_flags <= w_alu_flags;
        end
    end

    assign o_alu_op1  = r_op1;
    assign o_alu_op2  = r_op2;
    assign o_alu_func = r_func;
    assign o_flags    = r_flags;
    assign o_wb_valid = r_wb_valid;

endmodule
